// File: rtl/sdram_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_req_arbiter_if
//
// Bundles the two requester handshakes and the SDRAM FIFO write port that
// sdram_req_arbiter drives.
//
// Requester m0 (acquisition writer) and m1 (host reader), N = 0/1:
//   mN_req    requester -> arbiter  word valid
//   mN_rnw    requester -> arbiter  1 = read, 0 = write
//   mN_addr   requester -> arbiter  SDRAM word address
//   mN_wdata  requester -> arbiter  write data (ignored when rnw = 1)
//   mN_last   requester -> arbiter  final word of the burst
//   mN_ack    arbiter -> requester  word accepted this cycle
// FIFO side:
//   fifo_full     FIFO -> arbiter   FIFO cannot take a word
//   fifo_wr       arbiter -> FIFO   write strobe
//   fifo_wr_data  arbiter -> FIFO   {id, rnw, addr, wdata}
// Status:
//   grant      one-hot owner {m1, m0}, 00 when idle
//   burst_cnt  words accepted in the current grant
//
// Modports: slave = the arbiter, master = the environment driving it.
// ---------------------------------------------------------------------------
interface sdram_req_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
);
  logic                     m0_req;
  logic                     m0_rnw;
  logic [ADDR_W-1:0]        m0_addr;
  logic [DATA_W-1:0]        m0_wdata;
  logic                     m0_last;
  logic                     m0_ack;

  logic                     m1_req;
  logic                     m1_rnw;
  logic [ADDR_W-1:0]        m1_addr;
  logic [DATA_W-1:0]        m1_wdata;
  logic                     m1_last;
  logic                     m1_ack;

  logic                     fifo_full;
  logic                     fifo_wr;
  logic [ADDR_W+DATA_W+1:0] fifo_wr_data;

  logic [1:0]               grant;
  logic [3:0]               burst_cnt;

  modport slave (
    input  m0_req, m0_rnw, m0_addr, m0_wdata, m0_last,
    input  m1_req, m1_rnw, m1_addr, m1_wdata, m1_last,
    input  fifo_full,
    output m0_ack, m1_ack,
    output fifo_wr, fifo_wr_data,
    output grant, burst_cnt
  );

  modport master (
    output m0_req, m0_rnw, m0_addr, m0_wdata, m0_last,
    output m1_req, m1_rnw, m1_addr, m1_wdata, m1_last,
    output fifo_full,
    input  m0_ack, m1_ack,
    input  fifo_wr, fifo_wr_data,
    input  grant, burst_cnt
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_req_arbiter
//
// Round-robin arbiter sharing the SDRAM command/data FIFO write port between
// the acquisition writer (m0) and the host reader (m1). One requester owns
// the port at a time; it keeps ownership for a burst of up to MAX_BURST
// words, and words are pushed into the FIFO only while it is not full.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      sdram_req_arbiter_if.slave (requester handshakes, FIFO write
//            port, grant and burst_cnt status)
// ---------------------------------------------------------------------------
module sdram_req_arbiter #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sdram_req_arbiter_if.slave    bus
);

  localparam logic [3:0] MAX_CNT = MAX_BURST[3:0];

  // Encoding equals the one-hot grant, so grant is the state register itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       last_owner_reg, last_owner_next;

  // Fields of the current owner (m0 when not in GNT1).
  logic       cur_id;
  logic       own_req, own_last, own_ack, other_req;
  logic [3:0] cnt_inc;
  logic       rel_drop, rel_done;

  // Same-cycle accept: only the owner, only while the FIFO has room.
  assign bus.m0_ack  = (state_reg == GNT0) && bus.m0_req && !bus.fifo_full;
  assign bus.m1_ack  = (state_reg == GNT1) && bus.m1_req && !bus.fifo_full;
  assign bus.fifo_wr = bus.m0_ack || bus.m1_ack;

  assign bus.fifo_wr_data = (state_reg == GNT1)
    ? {1'b1, bus.m1_rnw, bus.m1_addr, bus.m1_wdata}
    : {1'b0, bus.m0_rnw, bus.m0_addr, bus.m0_wdata};

  assign bus.grant     = state_reg;
  assign bus.burst_cnt = cnt_reg;

  assign cur_id    = (state_reg == GNT1);
  assign own_req   = cur_id ? bus.m1_req  : bus.m0_req;
  assign own_last  = cur_id ? bus.m1_last : bus.m0_last;
  assign own_ack   = cur_id ? bus.m1_ack  : bus.m0_ack;
  assign other_req = cur_id ? bus.m0_req  : bus.m1_req;
  assign cnt_inc   = cnt_reg + 4'd1;

  // Release reasons: requester walked away, or the burst is complete
  // (explicit last word, or this ack fills the burst to MAX_BURST).
  assign rel_drop = !own_req;
  assign rel_done = own_ack && (own_last || (cnt_inc == MAX_CNT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      last_owner_reg <= 1'b1;   // m0 wins the first tie
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_owner_reg <= last_owner_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_owner_next = last_owner_reg;

    case (state_reg)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          state_next = last_owner_reg ? GNT0 : GNT1;
          cnt_next   = 4'd0;
        end else if (bus.m0_req) begin
          state_next = GNT0;
          cnt_next   = 4'd0;
        end else if (bus.m1_req) begin
          state_next = GNT1;
          cnt_next   = 4'd0;
        end
      end

      GNT0, GNT1: begin
        if (rel_drop || rel_done) begin
          last_owner_next = cur_id;
          if (other_req) begin
            // Pending peer always takes over: this is what prevents starvation.
            state_next = cur_id ? GNT0 : GNT1;
            cnt_next   = 4'd0;
          end else if (!rel_drop) begin
            // Same requester still asking: start a fresh burst.
            cnt_next = 4'd0;
          end else begin
            // Abandoned with nobody waiting; the final count stays visible.
            state_next = IDLE;
          end
        end else if (own_ack && (cnt_reg != MAX_CNT)) begin
          cnt_next = cnt_inc;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_req_arbiter
//
// Directed bench for sdram_req_arbiter. Inputs change on the falling edge;
// outputs are compared 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_sdram_req_arbiter;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  sdram_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the full output set for one cycle and print one line for it.
  task automatic chk_cycle(input string tag, input logic [1:0] g, input logic [3:0] cnt,
                           input logic a0, input logic a1, input logic [39:0] data);
    chk({tag, ".grant"}, 40'(bus.grant), 40'(g));
    chk({tag, ".burst_cnt"}, 40'(bus.burst_cnt), 40'(cnt));
    chk({tag, ".m0_ack"}, 40'(bus.m0_ack), 40'(a0));
    chk({tag, ".m1_ack"}, 40'(bus.m1_ack), 40'(a1));
    chk({tag, ".fifo_wr"}, 40'(bus.fifo_wr), 40'(a0 | a1));
    if (a0 | a1)
      chk({tag, ".fifo_wr_data"}, bus.fifo_wr_data, data);
    $display("%0t %s grant=%b cnt=%0d ack0=%b ack1=%b wr=%b data=%h", $time, tag,
             bus.grant, bus.burst_cnt, bus.m0_ack, bus.m1_ack, bus.fifo_wr, bus.fifo_wr_data);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic clear_inputs();
    bus.m0_req = 1'b0; bus.m0_rnw = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_last = 1'b0;
    bus.m1_req = 1'b0; bus.m1_rnw = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_last = 1'b0;
    bus.fifo_full = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    clear_inputs();

    // ---- Reset state ----
    @(negedge clk); #1;
    chk_cycle("reset", 2'b00, 4'd0, 1'b0, 1'b0, 40'd0);
    reset_n = 1'b1;

    // ---- Single word from m0 ----
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_addr = 22'h000010; bus.m0_wdata = 16'hA5A5; bus.m0_last = 1'b1;
    #1 chk_cycle("single.idle", 2'b00, 4'd0, 1'b0, 1'b0, 40'd0);
    @(negedge clk); #1;
    chk_cycle("single.word", 2'b01, 4'd0, 1'b1, 1'b0, {1'b0, 1'b0, 22'h000010, 16'hA5A5});
    @(negedge clk);
    bus.m0_req = 1'b0; bus.m0_last = 1'b0;
    #1 chk_cycle("single.regrant_drop", 2'b01, 4'd0, 1'b0, 1'b0, 40'd0);
    @(negedge clk); #1;
    chk_cycle("single.idle_after", 2'b00, 4'd0, 1'b0, 1'b0, 40'd0);

    // ---- Both requesters from reset, 3-word bursts each ----
    do_reset();
    bus.m0_req = 1'b1; bus.m0_rnw = 1'b0;
    bus.m1_req = 1'b1; bus.m1_rnw = 1'b1; bus.m1_addr = 22'h000200; bus.m1_wdata = 16'h0000;
    #1 chk_cycle("both.idle", 2'b00, 4'd0, 1'b0, 1'b0, 40'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.m0_addr = 22'h000100 + 22'(k); bus.m0_wdata = 16'h1000 + 16'(k); bus.m0_last = (k == 2);
      #1 chk_cycle("both.m0", 2'b01, 4'(k), 1'b1, 1'b0,
                   {1'b0, 1'b0, 22'h000100 + 22'(k), 16'h1000 + 16'(k)});
    end
    @(negedge clk);
    bus.m0_req = 1'b0; bus.m0_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      bus.m1_addr = 22'h000200 + 22'(k); bus.m1_wdata = 16'h2000 + 16'(k); bus.m1_last = (k == 2);
      #1 chk_cycle("both.m1", 2'b10, 4'(k), 1'b0, 1'b1,
                   {1'b1, 1'b1, 22'h000200 + 22'(k), 16'h2000 + 16'(k)});
    end
    @(negedge clk);
    bus.m1_req = 1'b0; bus.m1_last = 1'b0;
    #1 chk_cycle("both.m1_drop", 2'b10, 4'd0, 1'b0, 1'b0, 40'd0);
    @(negedge clk); #1;
    chk_cycle("both.idle_after", 2'b00, 4'd0, 1'b0, 1'b0, 40'd0);

    // ---- m0 without last hits MAX_BURST, m1 waiting takes over ----
    bus.m0_req = 1'b1; bus.m0_addr = 22'h000040; bus.m0_wdata = 16'h4444; bus.m0_last = 1'b0;
    bus.m1_req = 1'b1; bus.m1_rnw = 1'b0; bus.m1_addr = 22'h000050; bus.m1_wdata = 16'h5555; bus.m1_last = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk_cycle("max.m0", 2'b01, 4'(k), 1'b1, 1'b0, {1'b0, 1'b0, 22'h000040, 16'h4444});
    end
    @(negedge clk);
    bus.m0_req = 1'b0;
    #1 chk_cycle("max.switch_m1", 2'b10, 4'd0, 1'b0, 1'b1, {1'b1, 1'b0, 22'h000050, 16'h5555});
    @(negedge clk);
    bus.m1_req = 1'b0; bus.m1_last = 1'b0;
    @(negedge clk); #1;
    chk_cycle("max.idle_after", 2'b00, 4'd0, 1'b0, 1'b0, 40'd0);

    // ---- FIFO full for 4 cycles in the middle of an m1 burst ----
    bus.m1_req = 1'b1; bus.m1_rnw = 1'b0; bus.m1_addr = 22'h000300; bus.m1_wdata = 16'h3000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.m1_addr = 22'h000300 + 22'(k); bus.m1_wdata = 16'h3000 + 16'(k);
      #1 chk_cycle("full.pre", 2'b10, 4'(k), 1'b0, 1'b1, {1'b1, 1'b0, 22'h000300 + 22'(k), 16'h3000 + 16'(k)});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.fifo_full = 1'b1; bus.m1_addr = 22'h000302; bus.m1_wdata = 16'h3002;
      #1 chk_cycle("full.stall", 2'b10, 4'd2, 1'b0, 1'b0, 40'd0);
    end
    for (int k = 2; k < 4; k++) begin
      @(negedge clk);
      bus.fifo_full = 1'b0;
      bus.m1_addr = 22'h000300 + 22'(k); bus.m1_wdata = 16'h3000 + 16'(k); bus.m1_last = (k == 3);
      #1 chk_cycle("full.post", 2'b10, 4'(k), 1'b0, 1'b1, {1'b1, 1'b0, 22'h000300 + 22'(k), 16'h3000 + 16'(k)});
    end
    @(negedge clk);
    bus.m1_req = 1'b0; bus.m1_last = 1'b0;
    @(negedge clk); #1;
    chk_cycle("full.idle_after", 2'b00, 4'd0, 1'b0, 1'b0, 40'd0);

    // ---- m0 abandons after 2 words, then re-requests ----
    bus.m0_req = 1'b1; bus.m0_addr = 22'h000600; bus.m0_wdata = 16'h6000; bus.m0_last = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk_cycle("drop.m0", 2'b01, 4'(k), 1'b1, 1'b0, {1'b0, 1'b0, 22'h000600, 16'h6000});
    end
    @(negedge clk);
    bus.m0_req = 1'b0;
    #1 chk_cycle("drop.abandon", 2'b01, 4'd2, 1'b0, 1'b0, 40'd0);
    @(negedge clk);
    bus.m0_req = 1'b1;
    #1 chk_cycle("drop.idle", 2'b00, 4'd2, 1'b0, 1'b0, 40'd0);
    @(negedge clk); #1;
    chk_cycle("drop.regrant", 2'b01, 4'd0, 1'b1, 1'b0, {1'b0, 1'b0, 22'h000600, 16'h6000});
    @(negedge clk); #1;
    chk_cycle("drop.second", 2'b01, 4'd1, 1'b1, 1'b0, {1'b0, 1'b0, 22'h000600, 16'h6000});

    // ---- Asynchronous reset mid-burst, then tie goes to m0 ----
    bus.m1_req = 1'b1; bus.m1_addr = 22'h000700; bus.m1_wdata = 16'h7000;
    #1 reset_n = 1'b0;
    #1 chk_cycle("areset.mid", 2'b00, 4'd0, 1'b0, 1'b0, 40'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk_cycle("areset.idle", 2'b00, 4'd0, 1'b0, 1'b0, 40'd0);
    @(negedge clk); #1;
    chk_cycle("areset.tie_m0", 2'b01, 4'd0, 1'b1, 1'b0, {1'b0, 1'b0, 22'h000600, 16'h6000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
